// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with load extraction, write-back select,
// load fault detection and a retired-instruction counter.
module writeback_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_reg_write,
    input  logic [4:0]       in_rd,
    input  logic [1:0]       in_wb_sel,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic [XLEN-1:0]  in_pc_plus4,
    input  logic [XLEN-1:0]  in_mem_rdata,
    output logic             RegWriteEn,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  data,
    output logic             wb_valid,
    output logic             load_fault,
    output logic [CNT_W-1:0] instret
);

    typedef struct packed {
        logic            valid;
        logic            wen;
        logic            fault;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_data;
    logic            is_load;
    logic            bad_load;
    wb_entry_t       nxt;

    always_comb begin
        byte_sel = in_mem_rdata[{in_addr_lo, 3'b000} +: 8];
        half_sel = in_addr_lo[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
        case (in_funct3)
            3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = in_mem_rdata;
        endcase
    end

    // Misaligned halfword/word accesses and unused funct3 codes fault.
    always_comb begin
        case (in_funct3)
            3'b001, 3'b101:         bad_load = in_addr_lo[0];
            3'b010:                 bad_load = |in_addr_lo;
            3'b011, 3'b110, 3'b111: bad_load = 1'b1;
            default:                bad_load = 1'b0;
        endcase
    end

    always_comb begin
        is_load   = (in_wb_sel == 2'b01);
        nxt.valid = in_valid;
        nxt.fault = in_valid & is_load & bad_load;
        nxt.wen   = in_valid & in_reg_write & (in_rd != 5'd0) & ~nxt.fault;
        nxt.rd    = in_rd;
        case (in_wb_sel)
            2'b01:   nxt.data = load_data;
            2'b10:   nxt.data = in_pc_plus4;
            default: nxt.data = in_alu_result;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            RegWriteEn <= 1'b0;
            rd         <= '0;
            data       <= '0;
            wb_valid   <= 1'b0;
            load_fault <= 1'b0;
            instret    <= '0;
        end else if (flush) begin
            wb_valid   <= 1'b0;
            RegWriteEn <= 1'b0;
            load_fault <= 1'b0;
        end else if (!stall) begin
            RegWriteEn <= nxt.wen;
            rd         <= nxt.rd;
            data       <= nxt.data;
            wb_valid   <= nxt.valid;
            load_fault <= nxt.fault;
            if (nxt.valid && !nxt.fault)
                instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus write-back select for the RV32I core.
- Captures the memory-stage result and sign/zero-extends load data by funct3 and byte offset.
- Selects ALU result, load data or PC+4, and drives the register file write port (RegWriteEn, rd, data) one cycle later.
- Also flags faulting loads and keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low
- stall  input  1  hold the stage contents
- flush  input  1  kill the entry being captured
- in_valid  input  1  memory stage holds a real instruction
- in_reg_write  input  1  instruction writes rd
- in_rd  input  5  destination register
- in_wb_sel  input  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
- in_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- in_addr_lo  input  2  low bits of the load address
- in_alu_result  input  XLEN  ALU result
- in_pc_plus4  input  XLEN  link value
- in_mem_rdata  input  XLEN  raw aligned word from data memory
- RegWriteEn  output  1  register file write enable
- rd  output  5  register file write address
- data  output  XLEN  register file write data
- wb_valid  output  1  stage holds a valid instruction
- load_fault  output  1  captured load was misaligned or had an illegal funct3
- instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset: rst is sampled at the clk edge, active-low; the stage has one clock and reset is synchronous.
  - When rst=0: RegWriteEn=0, rd=0, data=0, wb_valid=0, load_fault=0, instret=0.
  - Reset overrides flush and stall.
  - Reset mid-operation discards the held entry; no write occurs in the cycle after reset.
- Edge priority, applied at each edge with rst=1:
  - flush=1: wb_valid<=0, RegWriteEn<=0, load_fault<=0; rd and data are don't-care but are held. flush beats stall.
  - stall=1 (flush=0): all outputs hold. RegWriteEn stays asserted if it was asserted; rewriting the same register is idempotent. instret does not increment.
  - Otherwise: capture the new entry. Latency from inputs to outputs is exactly 1 cycle.
- Load extraction (in_wb_sel=01), computed from in_mem_rdata:
  - Byte select = in_addr_lo; halfword select = in_addr_lo[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Fault: load_fault<=in_valid & in_wb_sel==01 & any of:
  - LH/LHU with in_addr_lo[0]=1
  - LW with in_addr_lo!=0
  - funct3 in {011, 110, 111}
- Write enable: RegWriteEn<=in_valid & in_reg_write & (in_rd!=0) & !fault.
  - x0 is never written.
  - data is still captured for debug when RegWriteEn=0.
- wb_valid<=in_valid, including faulting entries.
- instret: increments by 1 on every capture edge where in_valid=1 and fault=0. Entries with in_rd=0 and non-writing instructions (stores, branches) still count.
  - Wraps modulo 2^CNT_W.
  - Never increments on a stall, flush or reset edge.
- in_wb_sel=11 behaves as 00.
- Purely a single register stage: no combinational input-to-output path.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 driven -> all outputs 0, instret=0; release -> first capture appears on the next edge.
- ALU write: in_valid=1, in_reg_write=1, in_rd=3, in_wb_sel=00, in_alu_result=45 -> one edge later RegWriteEn=1, rd=3, data=45, instret=1. Repeat with in_rd=0 -> RegWriteEn=0, instret=2.
- Load extraction with in_mem_rdata=0x80FF7F01:
  - LB, addr_lo=1 -> 0x0000007F
  - LB, addr_lo=2 -> 0xFFFFFFFF
  - LBU, addr_lo=3 -> 0x00000080
  - LH, addr_lo=2 -> 0xFFFF80FF
  - LHU, addr_lo=0 -> 0x00007F01
  - LW, addr_lo=0 -> 0x80FF7F01
- Faults: LW, addr_lo=2, in_rd=5 -> load_fault=1, RegWriteEn=0, wb_valid=1, instret unchanged. funct3=110 -> same result.
- Stall/flush:
  - Capture rd=7, data=0x1234; assert stall for 3 cycles with new inputs -> outputs hold, instret +1 total.
  - stall=1 and flush=1 together -> wb_valid=0, RegWriteEn=0.
- Wrap: CNT_W=4, retire 17 valid instructions -> instret=1.
